// File: rtl/ci_stim_pkg.sv
// ----------------------------------------------------------------------------
// ci_stim_pkg
// Shared types and constants for the biphasic pulse sequencer:
//   - state_t       : sequencer FSM states
//   - PAT_*         : 4-bit H-bridge switch patterns, packed as {sw4,sw3,sw2,sw1}
//   - ch_idx_w()    : width of a channel index (never narrower than 1 bit)
// ----------------------------------------------------------------------------
package ci_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PH1   = 3'd1,
        ST_GAP   = 3'd2,
        ST_PH2   = 3'd3,
        ST_DEAD  = 3'd4,
        ST_DISCH = 3'd5,
        ST_IPI   = 3'd6
    } state_t;

    // {sw4,sw3,sw2,sw1}
    localparam logic [3:0] PAT_OFF   = 4'b0000;
    localparam logic [3:0] PAT_CATH  = 4'b1001; // sw1 & sw4
    localparam logic [3:0] PAT_ANOD  = 4'b0110; // sw2 & sw3
    localparam logic [3:0] PAT_DISCH = 4'b1100; // sw3 & sw4, both electrodes to return

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ci_stim_ch_arb.sv
// ----------------------------------------------------------------------------
// ci_stim_ch_arb
// Combinational next-enabled-channel finder.
// Ports:
//   i_mask       enable mask, one bit per channel
//   i_cur_idx    channel that just finished its pulse
//   i_wrap       allow wrapping to the lowest enabled channel
//   o_next_idx   channel to pulse next (valid when o_valid)
//   o_valid      a next channel exists
//   o_frame_end  no enabled channel above i_cur_idx (the frame is complete)
//   o_first_idx  lowest enabled channel (used to begin a frame)
//   o_any        mask is non-empty
// ----------------------------------------------------------------------------
module ci_stim_ch_arb
    import ci_stim_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [CH_W-1:0]   i_cur_idx,
    input  logic              i_wrap,
    output logic [CH_W-1:0]   o_next_idx,
    output logic              o_valid,
    output logic              o_frame_end,
    output logic [CH_W-1:0]   o_first_idx,
    output logic              o_any
);

    logic [CH_W-1:0] w_above_idx;
    logic            w_above_found;
    logic [CH_W-1:0] w_first_idx;

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_above_idx   = '0;
        w_above_found = 1'b0;
        w_first_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_first_idx = CH_W'(i);
                if (i > int'(i_cur_idx)) begin
                    w_above_found = 1'b1;
                    w_above_idx   = CH_W'(i);
                end
            end
        end
    end

    assign o_any       = |i_mask;
    assign o_first_idx = w_first_idx;
    assign o_frame_end = ~w_above_found;
    assign o_valid     = w_above_found | (i_wrap & o_any);
    assign o_next_idx  = w_above_found ? w_above_idx : w_first_idx;

endmodule

// File: rtl/ci_stim_pulse_seq.sv
// ----------------------------------------------------------------------------
// ci_stim_pulse_seq
// Multi-channel biphasic pulse sequencer. Pulses one enabled channel at a time:
// PH1 -> GAP -> PH2 -> DEAD -> DISCH -> (IPI) -> next channel.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start              level, begins a frame when idle
//   i_stop               pulse, graceful stop after the current discharge
//   i_cont               1 = repeat frames
//   i_ch_en, i_pol       channel enable mask, per-channel polarity (1 = anodic-first)
//   i_phase_len, i_gap_len, i_ipi_len   timing, sampled on entry to PH1
//   o_sw1..o_sw4         per-channel H-bridge switches
//   o_ctrl               current-source enable
//   o_ch_idx             active channel
//   o_busy               not idle
//   o_frame_done         one-cycle pulse after the last pulse of a frame
// All outputs are registered from next-state decode, so they move on the same
// edge as the state register.
// ----------------------------------------------------------------------------
module ci_stim_pulse_seq
    import ci_stim_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int CNT_W     = 16,
    parameter  int DEAD_CYC  = 2,
    parameter  int DISCH_CYC = 8,
    localparam int CH_W      = ch_idx_w(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_cont,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic [NUM_CH-1:0] i_pol,
    input  logic [CNT_W-1:0]  i_phase_len,
    input  logic [CNT_W-1:0]  i_gap_len,
    input  logic [CNT_W-1:0]  i_ipi_len,
    output logic [NUM_CH-1:0] o_sw1,
    output logic [NUM_CH-1:0] o_sw2,
    output logic [NUM_CH-1:0] o_sw3,
    output logic [NUM_CH-1:0] o_sw4,
    output logic              o_ctrl,
    output logic [CH_W-1:0]   o_ch_idx,
    output logic              o_busy,
    output logic              o_frame_done
);

    // ------------------------------------------------------------------ state
    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CH_W-1:0]   r_ch_idx;
    logic [CH_W-1:0]   w_next_ch;
    logic              r_pol;
    logic              w_next_pol;
    logic              r_stop;

    // Per-pulse shadows, stored as (length - 1) ready to load the down-counter.
    logic [CNT_W-1:0]  r_phase_m1;
    logic [CNT_W-1:0]  r_gap_m1;
    logic [CNT_W-1:0]  r_ipi_len;

    logic              w_load;        // entering PH1: sample lengths and polarity
    logic              w_sel;         // pulse finished: pick the next channel
    logic              w_frame_done_nxt;
    logic              w_cnt_zero;
    logic              w_stop_req;
    logic [CNT_W-1:0]  w_in_phase_m1;
    logic [CNT_W-1:0]  w_in_gap_m1;

    logic [CH_W-1:0]   w_arb_next;
    logic              w_arb_valid;
    logic              w_arb_frame_end;
    logic [CH_W-1:0]   w_first_idx;
    logic              w_any;

    logic [3:0]        w_pat;
    logic [NUM_CH-1:0] w_ch_oh;

    // Phase length 0 behaves as 1; gaps shorter than the dead time are
    // stretched so the bridge never flips polarity without a full dead time.
    assign w_in_phase_m1 = (i_phase_len == '0) ? '0 : i_phase_len - CNT_W'(1);
    assign w_in_gap_m1   = (i_gap_len < CNT_W'(DEAD_CYC)) ? CNT_W'(DEAD_CYC - 1)
                                                          : i_gap_len - CNT_W'(1);
    assign w_cnt_zero    = (r_cnt == '0);
    assign w_stop_req    = r_stop | i_stop;

    ci_stim_ch_arb #(
        .NUM_CH (NUM_CH)
    ) u_ch_arb (
        .i_mask      (i_ch_en),
        .i_cur_idx   (r_ch_idx),
        .i_wrap      (i_cont),
        .o_next_idx  (w_arb_next),
        .o_valid     (w_arb_valid),
        .o_frame_end (w_arb_frame_end),
        .o_first_idx (w_first_idx),
        .o_any       (w_any)
    );

    // ------------------------------------------------------ next-state logic
    always_comb begin
        w_next_state     = r_state;
        w_cnt_nxt        = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
        w_next_ch        = r_ch_idx;
        w_next_pol       = r_pol;
        w_load           = 1'b0;
        w_sel            = 1'b0;
        w_frame_done_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_start && w_any) begin
                    w_next_ch = w_first_idx;
                    w_load    = 1'b1;
                end
            end
            ST_PH1: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_GAP;
                    w_cnt_nxt    = r_gap_m1;
                end
            end
            ST_GAP: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_PH2;
                    w_cnt_nxt    = r_phase_m1;
                end
            end
            ST_PH2: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_DEAD;
                    w_cnt_nxt    = CNT_W'(DEAD_CYC - 1);
                end
            end
            ST_DEAD: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_DISCH;
                    w_cnt_nxt    = CNT_W'(DISCH_CYC - 1);
                end
            end
            ST_DISCH: begin
                if (w_cnt_zero) begin
                    // A stop ends here: no IPI and no frame-done pulse.
                    if (w_stop_req) begin
                        w_next_state = ST_IDLE;
                    end else if (r_ipi_len != '0) begin
                        w_next_state = ST_IPI;
                        w_cnt_nxt    = r_ipi_len - CNT_W'(1);
                    end else begin
                        w_sel = 1'b1;
                    end
                end
            end
            ST_IPI: begin
                if (w_cnt_zero) begin
                    if (w_stop_req) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_sel = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Channel select: the mask is sampled now, so mid-frame mask edits
        // take effect at the next pulse boundary.
        if (w_sel) begin
            w_frame_done_nxt = w_arb_frame_end;
            if (w_arb_valid) begin
                w_next_ch = w_arb_next;
                w_load    = 1'b1;
            end else begin
                w_next_state     = ST_IDLE;
                w_frame_done_nxt = 1'b1;
            end
        end

        if (w_load) begin
            w_next_state = ST_PH1;
            w_cnt_nxt    = w_in_phase_m1;
            w_next_pol   = i_pol[w_next_ch];
        end
    end

    // -------------------------------------------------- pattern decode / fan-out
    always_comb begin
        unique case (w_next_state)
            ST_PH1:   w_pat = w_next_pol ? PAT_ANOD : PAT_CATH;
            ST_PH2:   w_pat = w_next_pol ? PAT_CATH : PAT_ANOD;
            ST_DISCH: w_pat = PAT_DISCH;
            default:  w_pat = PAT_OFF;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            w_ch_oh[c] = (w_next_ch == CH_W'(c));
        end
    end

    // ---------------------------------------------------------- state registers
    // NOTE: every register here, including the shadow copies, is reset so the
    // block comes out of reset in a fully defined, all-switches-off state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_ch_idx     <= '0;
            r_pol        <= 1'b0;
            r_stop       <= 1'b0;
            r_phase_m1   <= '0;
            r_gap_m1     <= '0;
            r_ipi_len    <= '0;
            o_sw1        <= '0;
            o_sw2        <= '0;
            o_sw3        <= '0;
            o_sw4        <= '0;
            o_ctrl       <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state  <= w_next_state;
            r_cnt    <= w_cnt_nxt;
            r_ch_idx <= w_next_ch;
            r_pol    <= w_next_pol;

            // Stop is ignored while idle and cleared on every return to idle.
            if (w_next_state == ST_IDLE) begin
                r_stop <= 1'b0;
            end else if (i_stop && (r_state != ST_IDLE)) begin
                r_stop <= 1'b1;
            end

            if (w_load) begin
                r_phase_m1 <= w_in_phase_m1;
                r_gap_m1   <= w_in_gap_m1;
                r_ipi_len  <= i_ipi_len;
            end

            o_sw1        <= w_ch_oh & {NUM_CH{w_pat[0]}};
            o_sw2        <= w_ch_oh & {NUM_CH{w_pat[1]}};
            o_sw3        <= w_ch_oh & {NUM_CH{w_pat[2]}};
            o_sw4        <= w_ch_oh & {NUM_CH{w_pat[3]}};
            o_ctrl       <= (w_next_state == ST_PH1) || (w_next_state == ST_PH2);
            o_busy       <= (w_next_state != ST_IDLE);
            o_frame_done <= w_frame_done_nxt;
        end
    end

    assign o_ch_idx = r_ch_idx;

endmodule

// File: tb/tb_ci_stim_pulse_seq.sv
// ----------------------------------------------------------------------------
// tb_ci_stim_pulse_seq
// Self-checking bench for ci_stim_pulse_seq (NUM_CH=4, DEAD_CYC=2, DISCH_CYC=4).
// Each scenario pushes the expected per-cycle output vectors into a queue when
// its stimulus is driven; a monitor pops one vector per clock and compares.
// ----------------------------------------------------------------------------
module tb_ci_stim_pulse_seq;

    localparam int NUM_CH    = 4;
    localparam int CNT_W     = 16;
    localparam int DEAD_CYC  = 2;
    localparam int DISCH_CYC = 4;

    // Expected switch patterns, {sw4,sw3,sw2,sw1}
    localparam logic [3:0] E_OFF   = 4'b0000;
    localparam logic [3:0] E_CATH  = 4'b1001;
    localparam logic [3:0] E_ANOD  = 4'b0110;
    localparam logic [3:0] E_DISCH = 4'b1100;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic              i_stop;
    logic              i_cont;
    logic [NUM_CH-1:0] i_ch_en;
    logic [NUM_CH-1:0] i_pol;
    logic [CNT_W-1:0]  i_phase_len;
    logic [CNT_W-1:0]  i_gap_len;
    logic [CNT_W-1:0]  i_ipi_len;
    logic [NUM_CH-1:0] o_sw1, o_sw2, o_sw3, o_sw4;
    logic              o_ctrl;
    logic [1:0]        o_ch_idx;
    logic              o_busy;
    logic              o_frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // {sw1,sw2,sw3,sw4,ctrl,busy,frame_done,ch_idx}
    logic [20:0] sb[$];

    ci_stim_pulse_seq #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .DEAD_CYC  (DEAD_CYC),
        .DISCH_CYC (DISCH_CYC)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_cont       (i_cont),
        .i_ch_en      (i_ch_en),
        .i_pol        (i_pol),
        .i_phase_len  (i_phase_len),
        .i_gap_len    (i_gap_len),
        .i_ipi_len    (i_ipi_len),
        .o_sw1        (o_sw1),
        .o_sw2        (o_sw2),
        .o_sw3        (o_sw3),
        .o_sw4        (o_sw4),
        .o_ctrl       (o_ctrl),
        .o_ch_idx     (o_ch_idx),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [20:0] dut_vec();
        return {o_sw1, o_sw2, o_sw3, o_sw4, o_ctrl, o_busy, o_frame_done, o_ch_idx};
    endfunction

    // ------------------------------------------------------------ model
    task automatic push_cyc(input logic [3:0] pat, input int ch,
                            input bit ctrl, input bit busy, input bit fd);
        logic [3:0] oh;
        logic [3:0] s1, s2, s3, s4;
        oh = 4'b0001 << ch;
        s1 = pat[0] ? oh : 4'b0000;
        s2 = pat[1] ? oh : 4'b0000;
        s3 = pat[2] ? oh : 4'b0000;
        s4 = pat[3] ? oh : 4'b0000;
        sb.push_back({s1, s2, s3, s4, ctrl, busy, fd, 2'(ch)});
    endtask

    // One full pulse as seen at the outputs; fd_first marks the frame-done
    // flag carried by the first cycle, stopped drops the IPI.
    task automatic push_pulse(input int ch, input bit pol, input int phase,
                              input int gap, input int ipi, input bit fd_first,
                              input bit stopped);
        int p;
        int g;
        bit f;
        p = (phase == 0) ? 1 : phase;
        g = (gap < DEAD_CYC) ? DEAD_CYC : gap;
        f = fd_first;
        for (int k = 0; k < p; k++) begin
            push_cyc(pol ? E_ANOD : E_CATH, ch, 1'b1, 1'b1, f);
            f = 1'b0;
        end
        for (int k = 0; k < g; k++)         push_cyc(E_OFF, ch, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < p; k++)         push_cyc(pol ? E_CATH : E_ANOD, ch, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < DEAD_CYC; k++)  push_cyc(E_OFF, ch, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < DISCH_CYC; k++) push_cyc(E_DISCH, ch, 1'b0, 1'b1, 1'b0);
        if (!stopped) begin
            for (int k = 0; k < ipi; k++)   push_cyc(E_OFF, ch, 1'b0, 1'b1, 1'b0);
        end
    endtask

    // ---------------------------------------------------------- monitor
    initial begin
        logic [20:0] exp_v;
        logic        shoot;
        forever begin
            @(posedge i_clk);
            #1;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                check("out", 32'(dut_vec()), 32'(exp_v));
                shoot = o_ctrl & (|((o_sw1 & o_sw2) | (o_sw3 & o_sw4)));
                check("shoot_through", 32'(shoot), 32'd0);
            end
        end
    end

    // ---------------------------------------------------------- stimulus
    // Called at a negedge after expectations are pushed; returns in cycle 0.
    task automatic run_start(input logic [3:0] mask, input logic [3:0] pol,
                             input int phase, input int gap, input int ipi,
                             input bit cont);
        i_ch_en     = mask;
        i_pol       = pol;
        i_phase_len = CNT_W'(phase);
        i_gap_len   = CNT_W'(gap);
        i_ipi_len   = CNT_W'(ipi);
        i_cont      = cont;
        i_start     = 1'b1;
        @(negedge i_clk);
        i_start     = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_stop      = 1'b0;
        i_cont      = 1'b0;
        i_ch_en     = '0;
        i_pol       = '0;
        i_phase_len = '0;
        i_gap_len   = '0;
        i_ipi_len   = '0;
        repeat (2) @(negedge i_clk);
        check("reset_state", 32'(dut_vec()), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Single frame, ch0 then ch2, 19 cycles each.
        push_pulse(0, 1'b0, 3, 2, 5, 1'b0, 1'b0);
        push_pulse(2, 1'b0, 3, 2, 5, 1'b0, 1'b0);
        push_cyc(E_OFF, 2, 1'b0, 1'b0, 1'b1);
        push_cyc(E_OFF, 2, 1'b0, 1'b0, 1'b0);
        run_start(4'b0101, 4'b0000, 3, 2, 5, 1'b0);
        wait_drain("drain_single");

        // Polarity: ch0 anodic-first, ch1 cathodic-first.
        push_pulse(0, 1'b1, 2, 3, 0, 1'b0, 1'b0);
        push_pulse(1, 1'b0, 2, 3, 0, 1'b0, 1'b0);
        push_cyc(E_OFF, 1, 1'b0, 1'b0, 1'b1);
        run_start(4'b0011, 4'b0001, 2, 3, 0, 1'b0);
        wait_drain("drain_pol");

        // Boundary lengths: 1-cycle phases, gap raised to dead time, no IPI.
        push_pulse(1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        push_cyc(E_OFF, 1, 1'b0, 1'b0, 1'b1);
        push_cyc(E_OFF, 1, 1'b0, 1'b0, 1'b0);
        run_start(4'b0010, 4'b0000, 0, 0, 0, 1'b0);
        wait_drain("drain_bound");

        // Start with an empty mask stays idle.
        for (int k = 0; k < 3; k++) push_cyc(E_OFF, 1, 1'b0, 1'b0, 1'b0);
        run_start(4'b0000, 4'b0000, 3, 3, 3, 1'b0);
        wait_drain("drain_empty");

        // Continuous on ch3, stop during PH2 of the second pulse (cycle 19).
        push_pulse(3, 1'b0, 2, 2, 3, 1'b0, 1'b0);
        push_pulse(3, 1'b0, 2, 2, 3, 1'b1, 1'b1);
        push_cyc(E_OFF, 3, 1'b0, 1'b0, 1'b0);
        push_cyc(E_OFF, 3, 1'b0, 1'b0, 1'b0);
        run_start(4'b1000, 4'b0000, 2, 2, 3, 1'b1);
        repeat (19) @(negedge i_clk);
        i_stop = 1'b1;
        @(negedge i_clk);
        i_stop = 1'b0;
        i_cont = 1'b0;
        wait_drain("drain_stop");

        // Mask shrinks to ch0 during ch1's pulse; frame ends and wraps to ch0,
        // then a stop during that pulse ends the run.
        push_pulse(0, 1'b0, 1, 2, 0, 1'b0, 1'b0);
        push_pulse(1, 1'b0, 1, 2, 0, 1'b0, 1'b0);
        push_pulse(0, 1'b0, 1, 2, 0, 1'b1, 1'b1);
        push_cyc(E_OFF, 0, 1'b0, 1'b0, 1'b0);
        push_cyc(E_OFF, 0, 1'b0, 1'b0, 1'b0);
        run_start(4'b1111, 4'b0000, 1, 2, 0, 1'b1);
        repeat (12) @(negedge i_clk);
        i_ch_en = 4'b0001;
        repeat (10) @(negedge i_clk);
        i_stop = 1'b1;
        @(negedge i_clk);
        i_stop = 1'b0;
        i_cont = 1'b0;
        wait_drain("drain_mask");

        // Async reset during PH1, then a normal start.
        push_cyc(E_CATH, 0, 1'b1, 1'b1, 1'b0);
        push_cyc(E_CATH, 0, 1'b1, 1'b1, 1'b0);
        run_start(4'b0001, 4'b0000, 5, 2, 0, 1'b0);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_async", 32'(dut_vec()), 32'd0);
        @(negedge i_clk);
        check("rst_hold", 32'(dut_vec()), 32'd0);
        i_rst_n = 1'b1;
        wait_drain("drain_pre_rst");
        push_pulse(0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        push_cyc(E_OFF, 0, 1'b0, 1'b0, 1'b1);
        run_start(4'b0001, 4'b0000, 0, 0, 0, 1'b0);
        wait_drain("drain_post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ci_stim_pulse_seq.md
# ci_stim_pulse_seq

Parametrised multi-channel biphasic pulse sequencer that drives the H-bridge switch lines (sw1–sw4) and the current-source enable for `NUM_CH` electrode channels. It supersedes the single-channel fixed-pattern switch generator inside the stimulator wrapper. Pulses are issued in interleaved (non-simultaneous) order across enabled channels, with runtime-programmable phase, gap and inter-pulse timing, plus dead-time and discharge phases. It sits between the register/config block and the output pads inside the stimulator wrapper.

## Interface

Parameters:

- `NUM_CH`, default 4 — number of electrode channels (1..16).
- `CNT_W`, default 16 — width of all timing counters and length inputs.
- `DEAD_CYC`, default 2 — fixed all-switches-off cycles before discharge; also the minimum gap length (≥1).
- `DISCH_CYC`, default 8 — discharge phase length in cycles (≥1).

Ports (one clock; reset is asynchronous and active-low):

- `i_clk` in 1 — system clock.
- `i_rst_n` in 1 — asynchronous active-low reset.
- `i_start` in 1 — level; sampled in IDLE, begins a frame.
- `i_stop` in 1 — single-cycle pulse; requests graceful stop (latched).
- `i_cont` in 1 — 1 = repeat frames, 0 = single frame.
- `i_ch_en` in NUM_CH — channel enable mask.
- `i_pol` in NUM_CH — per-channel polarity; 0 = cathodic-first.
- `i_phase_len` in CNT_W — cycles per phase; 0 is treated as 1.
- `i_gap_len` in CNT_W — interphase gap cycles; values below DEAD_CYC are raised to DEAD_CYC.
- `i_ipi_len` in CNT_W — inter-pulse idle cycles; 0 means no IPI state.
- `o_sw1`, `o_sw2`, `o_sw3`, `o_sw4` out NUM_CH each — per-channel H-bridge switches.
- `o_ctrl` out 1 — current-source enable.
- `o_ch_idx` out $clog2(NUM_CH) (min 1) — active channel index.
- `o_busy` out 1 — high whenever not in IDLE.
- `o_frame_done` out 1 — one-cycle pulse at the end of each frame.

## Operation

- States: IDLE, PH1, GAP, PH2, DEAD, DISCH, IPI.
- Switch patterns (active channel only; all other channels are all-zero):
  - Cathodic-first: PH1 = sw1&sw4, PH2 = sw2&sw3.
  - `i_pol`=1 swaps the PH1 and PH2 patterns.
  - DISCH = sw3&sw4.
  - GAP, DEAD, IPI and IDLE = all off.
- `o_ctrl`=1 only in PH1 and PH2.
- Transitions:
  - IDLE→PH1 when `i_start`=1 and `i_ch_en`≠0. The first channel is the lowest enabled index.
  - PH1→GAP→PH2→DEAD→DISCH, each after its programmed count.
  - DISCH→IPI if `i_ipi_len`≠0, otherwise directly to channel select.
- Channel select: go to the next enabled index above the current one.
  - If none remains, the frame is done: `o_frame_done` pulses.
  - If `i_cont`=1, wrap to the lowest enabled index; otherwise go to IDLE.
- Length inputs and `i_pol` are sampled when entering PH1. They are held in shadow registers for the whole pulse, so mid-pulse changes are ignored.
- `i_ch_en` is sampled at each channel select.
- Mask empty at channel select → IDLE, and `o_frame_done` pulses.
- Stop handling:
  - `i_stop` sets a sticky flag.
  - The current pulse always completes through DISCH, then goes to IDLE. IPI is skipped and `o_frame_done` is not pulsed.
  - `i_stop` in IDLE is ignored and the flag clears on entering IDLE.
  - `i_stop` together with `i_start` in IDLE: start wins.
- Reset mid-operation: all outputs drop to 0 asynchronously and the FSM goes to IDLE. No discharge is forced.

## Timing

- All outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- Reset values:
  - `o_sw1`–`o_sw4` = 0.
  - `o_ctrl`, `o_busy`, `o_frame_done` = 0.
  - `o_ch_idx` = 0.
  - State = IDLE.
- Start latency: `i_start` sampled high at edge k → PH1 patterns and `o_busy` valid from edge k.
- Per-pulse length: P + max(G,DEAD_CYC) + P + DEAD_CYC + DISCH_CYC + I cycles, where P = max(`i_phase_len`,1).
- Pulse boundaries: the next channel's PH1 begins on the cycle immediately after the last IPI/DISCH cycle. There is no extra cycle between pulses.
- `o_frame_done` is asserted in the first cycle after the last pulse of the frame, coincident with the next PH1 or with IDLE.
- Counters: down-count from length−1 to 0 with an explicit compare. No wrap; CNT_W all-ones is a legal length.

## Structure

- Package `ci_stim_pkg` holds:
  - the state enum;
  - the switch-pattern constants (PAT_CATH, PAT_ANOD, PAT_DISCH, PAT_OFF as 4-bit {sw4,sw3,sw2,sw1});
  - the width helper for `o_ch_idx`.
- Sub-module `ci_stim_ch_arb`: combinational next-enabled-channel finder (mask, current index, wrap → next index, valid, frame_end).
- The top level contains the FSM, the shadow registers and the per-channel pattern fan-out.

## Test plan

All scenarios use NUM_CH=4, DEAD_CYC=2, DISCH_CYC=4.

- Single frame: mask 0b0101, phase=3, gap=2, ipi=5, cont=0 → ch0 then ch2. Each pulse 19 cycles. `o_frame_done` pulses once and `o_busy` falls after 38 cycles.
- Polarity: pol=0b0001, mask 0b0011 → ch0 PH1 = sw2&sw3, ch1 PH1 = sw1&sw4. No channel ever has sw1&sw2 or sw3&sw4 asserted together with `o_ctrl`=1.
- Boundary lengths: phase=0, gap=0, ipi=0 → PH1 and PH2 last 1 cycle, GAP lasts 2, no IPI state. Pulse = 10 cycles.
- Continuous mode with stop: cont=1, mask 0b1000 → ch3 repeats. `i_stop` mid-PH2 → DISCH completes, then IDLE with no IPI and no `o_frame_done`.
- Mid-frame mask change: mask 0b1111 → 0b0001 during ch1 → after ch1, frame ends, `o_frame_done` pulses, and ch0 follows if cont=1.
- Async reset asserted during PH1 → all switches and `o_ctrl` are 0 before the next clock edge, and start works normally after release.
